mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 nrst  input  1  reset; synchronous, active-low.
REQ-003 valid_i  input  1  EX/MEM slot holds a live instruction this cycle.
REQ-004 MemRead, MemWrite  input  1 each  load / store request from EX/MEM control.
REQ-005 ALUResult  input  64  byte address of the access.
REQ-006 wdata_i  input  64  store data (rs2 value, LSB-justified).
REQ-007 funct3_i  input  3  access size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-008 wmask  input  8  byte-enable for stores, lane-aligned to ALUResult[2:0].
REQ-009 mem_req, mem_we  output  1 each  data-memory request and write-enable.
REQ-010 mem_addr  output  64  doubleword-aligned address (ALUResult with [2:0] zeroed).
REQ-011 mem_wdata, mem_wmask  output  64, 8  lane-shifted store data and byte enables.
REQ-012 mem_ack  input  1  memory completes the current request.
REQ-013 mem_rdata  input  64  raw doubleword read data, valid with mem_ack.
REQ-014 stall_o  output  1  freezes PC, IF/ID, ID/EX, EX/MEM; inserts bubble into MEM/WB.
REQ-015 rdata  output  64  extended load result, feeds MEM/WB rdata.
REQ-016 done_o  output  1  one-cycle pulse: access complete, rdata valid.
REQ-017 misalign_o  output  1  one-cycle pulse: access rejected as misaligned.

Function
REQ-018 FSM states IDLE, BUSY, DONE; encoding 2 bits.
REQ-019 IDLE->BUSY when valid_i and (MemRead or MemWrite) and aligned; address, funct3, wdata, wmask, we latched that edge.
REQ-020 Alignment: h needs addr[0]=0, w needs addr[1:0]=0, d needs addr[2:0]=0; b always aligned.
REQ-021 Misaligned access: stay IDLE, misalign_o=1 next cycle for one cycle, no mem_req, no stall.
REQ-022 valid_i with neither MemRead nor MemWrite: no request, no stall, no done_o.
REQ-023 MemRead and MemWrite both set: treated as store; load data discarded.
REQ-024 BUSY: mem_req=1 held with stable addr/data/mask until mem_ack; mem_we=latched MemWrite.
REQ-025 BUSY->DONE on mem_ack; load data captured, extended, registered into rdata that edge.
REQ-026 DONE: done_o=1, mem_req=0, stall_o=0; DONE->IDLE unconditionally (no back-to-back acceptance from DONE).
REQ-027 stall_o = (IDLE and accepted access start) or BUSY; combinational from state and inputs.
REQ-028 Minimum latency: start cycle + 1 BUSY cycle (ack same cycle) -> done_o 2 cycles after acceptance.
REQ-029 Load extension: select byte/half/word by addr[2:0]; signed sizes sign-extend, u-sizes zero-extend to 64.
REQ-030 Store: mem_wdata = wdata_i shifted left by 8*addr[2:0]; mem_wmask = wmask unchanged.
REQ-031 rdata holds last load value until next completed load; stores do not modify rdata.
REQ-032 mem_ack in IDLE or DONE ignored.

Reset
REQ-033 nrst low at edge: state=IDLE, rdata=0, done_o=0, misalign_o=0, latched regs=0.
REQ-034 Reset mid-BUSY abandons request: mem_req=0 next cycle, no done_o; late ack ignored.
REQ-035 Outputs mem_req, mem_we, stall_o = 0 while in reset state.

Structure
REQ-036 Shared package holds funct3 size constants, FSM state encoding, XLEN=64.
REQ-037 One combinational sub-module load_extend (raw doubleword, addr[2:0], funct3 -> 64-bit result).

Verification
REQ-038 ld addr 0x100, ack after 3 BUSY cycles, rdata raw 0x1122334455667788 -> stall 4 cycles, done_o, rdata=0x1122334455667788.
REQ-039 lb addr 0x103, raw 0x0000_0000_8000_0000 -> rdata=0xFFFFFFFFFFFFFF80; lbu same -> 0x0000000000000080.
REQ-040 sw addr 0x204, wdata 0xDEADBEEF, wmask 0xF0, ack immediate -> mem_addr 0x200, mem_wdata 0xDEADBEEF00000000, mem_we=1, rdata unchanged.
REQ-041 lw addr 0x102 -> misalign_o pulse, mem_req never asserted, stall_o=0.
REQ-042 nrst low during BUSY, ack arrives after reset -> no done_o, state IDLE, rdata=0.
REQ-043 Two back-to-back loads -> second accepted only in cycle after DONE; one done_o per load.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data access unit: data width,
// funct3 access-size codes, FSM state encoding and the alignment rule.
package mem_access_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Natural alignment check for an access of size funct3 at byte offset off.
  // The unused code 3'b111 is treated like a doubleword.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] off);
    logic ok;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = (off[0] == 1'b0);
      F3_W, F3_WU: ok = (off[1:0] == 2'b00);
      default:     ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Selects the addressed byte/half/word lane from a raw doubleword and
// sign- or zero-extends it to XLEN according to funct3.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  // Right-justify the addressed lane, then extend by access size.
  always_comb begin
    shifted = raw >> {offset, 3'b000};
    case (funct3)
      F3_B:    result = {{56{shifted[7]}},  shifted[7:0]};
      F3_BU:   result = {56'd0,             shifted[7:0]};
      F3_H:    result = {{48{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {48'd0,             shifted[15:0]};
      F3_W:    result = {{32{shifted[31]}}, shifted[31:0]};
      F3_WU:   result = {32'd0,             shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data memory access unit: accepts a load/store from EX/MEM,
// holds a request to data memory until acknowledged, stalls the pipeline
// meanwhile, and returns extended load data with a one-cycle done pulse.
module mem_access
  import mem_access_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            valid_i,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [7:0]      wmask,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall_o,
  output logic [XLEN-1:0] rdata,
  output logic            done_o,
  output logic            misalign_o
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic [7:0]      wmask_q;
  logic            we_q;
  logic [XLEN-1:0] load_value;

  logic access_req;
  logic aligned;
  logic start;
  logic reject;

  assign access_req = valid_i & (MemRead | MemWrite);
  assign aligned    = is_aligned(funct3_i, ALUResult[2:0]);
  assign start      = (state_q == ST_IDLE) & access_req & aligned;
  assign reject     = (state_q == ST_IDLE) & access_req & ~aligned;

  assign mem_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
  assign mem_wmask = wmask_q;

  load_extend u_load_extend (
    .raw    (mem_rdata),
    .offset (addr_q[2:0]),
    .funct3 (funct3_q),
    .result (load_value)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; stall covers the accept cycle too.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_o = start;
        if (start) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        stall_o = 1'b1;
        if (mem_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches, load result capture and misalignment pulse.
  // A load+store combination latches we=1, so it completes as a store and
  // leaves rdata untouched.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      wmask_q    <= '0;
      we_q       <= 1'b0;
      rdata      <= '0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= reject;
      if (start) begin
        addr_q   <= ALUResult;
        wdata_q  <= wdata_i;
        funct3_q <= funct3_i;
        wmask_q  <= wmask;
        we_q     <= MemWrite;
      end
      if ((state_q == ST_BUSY) && mem_ack && !we_q)
        rdata <= load_value;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        nrst;
  logic        valid_i, MemRead, MemWrite;
  logic [63:0] ALUResult, wdata_i;
  logic [2:0]  funct3_i;
  logic [7:0]  wmask;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall_o;
  logic [63:0] rdata;
  logic        done_o, misalign_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_access dut (
    .clk        (clk),
    .nrst       (nrst),
    .valid_i    (valid_i),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .wdata_i    (wdata_i),
    .funct3_i   (funct3_i),
    .wmask      (wmask),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall_o    (stall_o),
    .rdata      (rdata),
    .done_o     (done_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    mem_ack  = 1'b0;
  endtask

  // Present one access, ack it after ack_after BUSY cycles, return in DONE.
  task automatic run_access(
    input  logic [63:0] addr, input logic [2:0] f3, input logic [63:0] wd,
    input  logic [7:0] wm, input logic rd, input logic wr,
    input  logic [63:0] raw, input int ack_after,
    output int stalls, output logic [63:0] c_addr, output logic [63:0] c_wdata,
    output logic c_we, output logic [7:0] c_mask);
    valid_i = 1'b1; MemRead = rd; MemWrite = wr;
    ALUResult = addr; funct3_i = f3; wdata_i = wd; wmask = wm; mem_ack = 1'b0;
    stalls = 0; c_addr = '0; c_wdata = '0; c_we = 1'b0; c_mask = '0;
    #1;
    if (stall_o) stalls++;
    cyc();
    for (int i = 1; i <= ack_after; i++) begin
      if (i == ack_after) begin
        mem_ack = 1'b1;
        mem_rdata = raw;
      end
      #1;
      if (stall_o) stalls++;
      c_addr = mem_addr; c_wdata = mem_wdata; c_we = mem_we; c_mask = mem_wmask;
      cyc();
      mem_ack = 1'b0;
    end
    idle_inputs();
    #1;
  endtask

  int          st;
  logic [63:0] ca, cw;
  logic        cwe;
  logic [7:0]  cm;

  typedef struct {
    string       tag;
    logic [63:0] addr;
    logic [2:0]  f3;
    logic [63:0] raw;
    logic [63:0] exp;
  } ld_vec_t;

  ld_vec_t lv[6];

  initial begin
    int dones;

    nrst = 1'b0;
    idle_inputs();
    ALUResult = '0; wdata_i = '0; funct3_i = '0; wmask = '0; mem_rdata = '0;
    cyc(); cyc();
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_stall",   stall_o, 0);
    check_eq("rst_done",    done_o, 0);
    check_eq("rst_misalign", misalign_o, 0);
    check_eq("rst_rdata",   rdata, 0);
    nrst = 1'b1;
    cyc();

    // ld with three BUSY cycles
    run_access(64'h100, 3'b011, '0, 8'hFF, 1'b1, 1'b0, 64'h1122334455667788, 3, st, ca, cw, cwe, cm);
    check_eq("ld_stalls", st, 4);
    check_eq("ld_addr",   ca, 64'h100);
    check_eq("ld_we",     cwe, 0);
    check_eq("ld_done",   done_o, 1);
    check_eq("ld_stall_done", stall_o, 0);
    check_eq("ld_rdata",  rdata, 64'h1122334455667788);
    cyc();
    check_eq("ld_done_pulse", done_o, 0);

    // load extension table
    lv[0] = '{"lb",  64'h103, 3'b000, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    lv[1] = '{"lbu", 64'h103, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080};
    lv[2] = '{"lh",  64'h106, 3'b001, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001};
    lv[3] = '{"lhu", 64'h106, 3'b101, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001};
    lv[4] = '{"lw",  64'h104, 3'b010, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF};
    lv[5] = '{"lwu", 64'h104, 3'b110, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF};
    foreach (lv[k]) begin
      run_access(lv[k].addr, lv[k].f3, '0, 8'h00, 1'b1, 1'b0, lv[k].raw, 1, st, ca, cw, cwe, cm);
      check_eq({lv[k].tag, "_rdata"}, rdata, lv[k].exp);
      check_eq({lv[k].tag, "_stalls"}, st, 2);
      cyc();
    end
    // rdata now 0x00000000_89ABCDEF from lwu

    // sw immediate ack
    run_access(64'h204, 3'b010, 64'hDEADBEEF, 8'hF0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, st, ca, cw, cwe, cm);
    check_eq("sw_addr",  ca, 64'h200);
    check_eq("sw_wdata", cw, 64'hDEADBEEF_00000000);
    check_eq("sw_we",    cwe, 1);
    check_eq("sw_mask",  cm, 8'hF0);
    check_eq("sw_done",  done_o, 1);
    check_eq("sw_rdata", rdata, 64'h0000_0000_89AB_CDEF);
    cyc();

    // load+store together behaves as store
    run_access(64'h300, 3'b011, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b1, 64'h5555_5555_5555_5555, 2, st, ca, cw, cwe, cm);
    check_eq("rw_we",    cwe, 1);
    check_eq("rw_wdata", cw, 64'h0123_4567_89AB_CDEF);
    check_eq("rw_rdata", rdata, 64'h0000_0000_89AB_CDEF);
    cyc();

    // misaligned lw
    valid_i = 1'b1; MemRead = 1'b1; ALUResult = 64'h102; funct3_i = 3'b010;
    #1;
    check_eq("mis_stall", stall_o, 0);
    check_eq("mis_req0",  mem_req, 0);
    cyc();
    idle_inputs();
    #1;
    check_eq("mis_pulse", misalign_o, 1);
    check_eq("mis_req1",  mem_req, 0);
    check_eq("mis_stall1", stall_o, 0);
    cyc();
    check_eq("mis_pulse_end", misalign_o, 0);
    check_eq("mis_req2", mem_req, 0);

    // valid without read or write
    valid_i = 1'b1; ALUResult = 64'h400; funct3_i = 3'b011;
    #1;
    check_eq("nop_stall", stall_o, 0);
    cyc();
    idle_inputs();
    #1;
    check_eq("nop_req",  mem_req, 0);
    check_eq("nop_done", done_o, 0);
    cyc();

    // reset during BUSY, late ack
    valid_i = 1'b1; MemRead = 1'b1; ALUResult = 64'h100; funct3_i = 3'b011;
    cyc();
    check_eq("rb_busy_req", mem_req, 1);
    nrst = 1'b0;
    cyc();
    nrst = 1'b1;
    idle_inputs();
    #1;
    check_eq("rb_req",   mem_req, 0);
    check_eq("rb_stall", stall_o, 0);
    check_eq("rb_rdata", rdata, 0);
    mem_ack = 1'b1; mem_rdata = 64'hCAFE_CAFE_CAFE_CAFE;
    cyc();
    mem_ack = 1'b0;
    #1;
    check_eq("rb_late_done", done_o, 0);
    check_eq("rb_late_req",  mem_req, 0);
    check_eq("rb_late_rdata", rdata, 0);
    cyc();

    // back-to-back loads, valid held high throughout
    dones = 0;
    valid_i = 1'b1; MemRead = 1'b1; ALUResult = 64'h100; funct3_i = 3'b011;
    #1;
    check_eq("bb_start1", stall_o, 1);
    cyc();
    mem_ack = 1'b1; mem_rdata = 64'hAAAA_0000_0000_1111;
    cyc();
    mem_ack = 1'b0;
    if (done_o) dones++;
    ALUResult = 64'h108; mem_rdata = 64'h2222_3333_4444_5555;
    #1;
    check_eq("bb_done1_rdata", rdata, 64'hAAAA_0000_0000_1111);
    check_eq("bb_done_stall", stall_o, 0);
    check_eq("bb_done_req",   mem_req, 0);
    cyc();
    if (done_o) dones++;
    check_eq("bb_start2", stall_o, 1);
    cyc();
    check_eq("bb_busy2", mem_req, 1);
    check_eq("bb_addr2", mem_addr, 64'h108);
    mem_ack = 1'b1;
    cyc();
    idle_inputs();
    #1;
    if (done_o) dones++;
    check_eq("bb_rdata2", rdata, 64'h2222_3333_4444_5555);
    cyc();
    if (done_o) dones++;
    check_eq("bb_dones", dones, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
